// File: rtl/ifetch_queue_if.sv
// Handshake bundle between the prefetch queue, instruction memory and the IF stage.
// master = prefetch queue side, slave = memory / IF / redirect source side.
interface ifetch_queue_if;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_ready;

  modport master (
    input  redirect, redirect_pc, mem_ack, mem_rdata, out_ready,
    output mem_req, mem_addr, out_valid, out_pc, out_inst
  );

  modport slave (
    output redirect, redirect_pc, mem_ack, mem_rdata, out_ready,
    input  mem_req, mem_addr, out_valid, out_pc, out_inst
  );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: one outstanding sequential fetch, DEPTH-entry {pc, inst} FIFO, redirect flush.
// Optional IFQ_STATS_EN adds saturating stat_fetched / stat_discarded counters.
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic           clk,
  input  logic           reset,
  ifetch_queue_if.master bus
`ifdef IFQ_STATS_EN
  ,
  output logic [31:0]    stat_fetched,
  output logic [15:0]    stat_discarded
`endif
);
  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = (AW)'(1);

  typedef enum logic [1:0] {FETCH = 2'd0, WAIT = 2'd1, DISCARD = 2'd2} state_t;

  state_t        state_reg, state_next;
  logic [31:0]   fetch_pc_reg, fetch_pc_next;
  logic [31:0]   addr_reg;
  logic [AW:0]   count_reg;
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic          req_en_reg;
  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   inst_mem [DEPTH];

  logic          req, ack, push, pop, valid;
  logic [31:0]   addr;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= FETCH;
      fetch_pc_reg <= RESET_PC;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
    end
  end

  // Next state; a redirect overrides everything, and only a still-unacked request forces DISCARD
  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    case (state_reg)
      FETCH:         if (req && !ack) state_next = WAIT;
      WAIT, DISCARD: if (ack)         state_next = FETCH;
      default:                        state_next = FETCH;
    endcase
    if (push) fetch_pc_next = fetch_pc_reg + 32'd4;
    if (bus.redirect) begin
      fetch_pc_next = bus.redirect_pc & ~32'h3;
      state_next    = (req && !ack) ? DISCARD : FETCH;
    end
  end

  // Outputs; in FETCH the request is combinational so req can stay high across an ack
  always_comb begin
    valid         = (count_reg != '0);
    req           = req_en_reg && ((state_reg != FETCH) || (count_reg < FULL));
    addr          = (state_reg == FETCH) ? fetch_pc_reg : addr_reg;
    bus.mem_req   = req;
    bus.mem_addr  = addr;
    bus.out_valid = valid;
    bus.out_pc    = valid ? pc_mem[rd_ptr_reg]   : '0;
    bus.out_inst  = valid ? inst_mem[rd_ptr_reg] : '0;
  end

  always_comb begin
    ack  = req && bus.mem_ack;
    push = ack && (state_reg != DISCARD) && !bus.redirect;
    pop  = valid && bus.out_ready && !bus.redirect;
  end

  // FIFO bookkeeping; req_en_reg keeps mem_req low for the first cycle out of reset
  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      addr_reg   <= RESET_PC;
      req_en_reg <= 1'b0;
    end else begin
      req_en_reg <= 1'b1;
      if (state_reg == FETCH) addr_reg <= fetch_pc_reg;
      if (bus.redirect) begin
        count_reg  <= '0;
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
        if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
        count_reg <= count_reg + (AW+1)'(push) - (AW+1)'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_reg]   <= addr;
      inst_mem[wr_ptr_reg] <= bus.mem_rdata;
    end
  end

`ifdef IFQ_STATS_EN
  logic        drop;
  logic [AW:0] flushed;
  logic [16:0] disc_sum;

  // Dropped words are acks that land in DISCARD or coincide with a redirect
  always_comb begin
    drop     = ack && ((state_reg == DISCARD) || bus.redirect);
    flushed  = bus.redirect ? count_reg : '0;
    disc_sum = {1'b0, stat_discarded} + 17'(flushed) + 17'(drop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_fetched   <= '0;
      stat_discarded <= '0;
    end else begin
      if (push && (stat_fetched != '1)) stat_fetched <= stat_fetched + 32'd1;
      stat_discarded <= disc_sum[16] ? 16'hFFFF : disc_sum[15:0];
    end
  end
`endif
endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: directed scenarios plus randomized traffic checked against a stream-level model.
module tb_ifetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'd0;

  logic clk = 1'b0;
  logic reset;
  ifetch_queue_if bus();
`ifdef IFQ_STATS_EN
  logic [31:0] stat_fetched;
  logic [15:0] stat_discarded;
`endif

  ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
`ifdef IFQ_STATS_EN
    ,
    .stat_fetched(stat_fetched),
    .stat_discarded(stat_discarded)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pops = 0;
  int pops_since_reset = 0;
  int lat_min = 1;
  int lat_max = 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h1E0F} + 32'h0101_0101;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Memory: acks each request after a per-request latency and checks the request is held until acked
  int          wait_cnt = 0;
  int          cur_lat = 0;
  bit          pend = 1'b0;
  logic [31:0] pend_addr = '0;
  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!reset && pend && !bus.mem_ack) begin
        chk("mem_req_held", bus.mem_req, 1);
        chk("mem_addr_held", bus.mem_addr, pend_addr);
      end
      if (reset || !bus.mem_req) begin
        bus.mem_ack = 1'b0;
        pend = 1'b0;
      end else begin
        if (!pend || bus.mem_ack) begin
          cur_lat  = $urandom_range(lat_max, lat_min);
          wait_cnt = 0;
        end
        if (wait_cnt >= cur_lat) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = word(bus.mem_addr);
        end else begin
          bus.mem_ack = 1'b0;
          wait_cnt++;
        end
        pend      = 1'b1;
        pend_addr = bus.mem_addr;
      end
    end
  end

  // Reference model: IF must see consecutive words from the last redirect target (or RESET_PC)
  logic [31:0] exp_pc = RESET_PC;
  bit          chk_flush = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (reset) begin
        exp_pc = RESET_PC;
        chk_flush = 1'b0;
        pops_since_reset = 0;
      end else begin
        if (chk_flush) begin
          chk("mon_flush_valid", bus.out_valid, 0);
          chk_flush = 1'b0;
        end
        if (bus.redirect) begin
          exp_pc = bus.redirect_pc & ~32'h3;
          chk_flush = 1'b1;
        end else if (bus.out_valid && bus.out_ready) begin
          chk("mon_pop_pc", bus.out_pc, exp_pc);
          chk("mon_pop_inst", bus.out_inst, word(exp_pc));
          exp_pc = exp_pc + 32'd4;
          pops++;
          pops_since_reset++;
        end
      end
    end
  end

  initial begin
    int n;
    int p0;
    logic [31:0] a;

    reset = 1'b1;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_addr", bus.mem_addr, RESET_PC);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_pc", bus.out_pc, 0);
    chk("rst_out_inst", bus.out_inst, 0);
`ifdef IFQ_STATS_EN
    chk("rst_stat_fetched", stat_fetched, 0);
    chk("rst_stat_discarded", {16'h0, stat_discarded}, 0);
`endif

    // 1: one-cycle memory, IF always ready
    reset = 1'b0;
    tick();
    chk("t1_first_req", bus.mem_req, 1);
    chk("t1_first_addr", bus.mem_addr, RESET_PC);
    bus.out_ready = 1'b1;
    n = 0;
    while (!bus.mem_ack && n < 20) begin tick(); n++; end
    chk("t1_ack_seen", bus.mem_ack, 1);
    chk("t1_empty_on_ack", bus.out_valid, 0);
    tick();
    chk("t1_valid_after_ack", bus.out_valid, 1);
    chk("t1_pc0", bus.out_pc, RESET_PC);
    chk("t1_inst0", bus.out_inst, word(RESET_PC));
    n = 0;
    while (pops < 4 && n < 40) begin tick(); n++; end
    chk("t1_four_pops", pops >= 4, 1);

    // 2: IF stalled, ack every cycle -> fills to DEPTH and stops requesting
    bus.out_ready = 1'b0;
    lat_min = 0; lat_max = 0;
    repeat (20) tick();
    chk("t2_full_no_req", bus.mem_req, 0);
    chk("t2_full_valid", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("t2_refill_req", bus.mem_req, 1);
    chk("t2_refill_ack", bus.mem_ack, 1);
    tick();
    chk("t2_full_again", bus.mem_req, 0);
    lat_min = 6; lat_max = 6;
    bus.out_ready = 1'b1;
    n = 0;
    while (bus.out_valid && n < 12) begin n++; tick(); end
    chk("t2_depth_entries", n, DEPTH);

    // 3: redirect while waiting on a slow ack
    chk("t3_wait_req", bus.mem_req, 1);
    a = bus.mem_addr;
    lat_min = 1; lat_max = 1;
    bus.out_ready = 1'b0;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h100;
    tick();
    bus.redirect = 1'b0;
    chk("t3_discard_req", bus.mem_req, 1);
    chk("t3_discard_addr", bus.mem_addr, a);
    chk("t3_flushed", bus.out_valid, 0);
    n = 0;
    while (!bus.mem_ack && n < 20) begin tick(); n++; end
    chk("t3_late_ack", bus.mem_ack, 1);
    tick();
    chk("t3_new_req", bus.mem_req, 1);
    chk("t3_new_addr", bus.mem_addr, 32'h100);
    chk("t3_dropped", bus.out_valid, 0);
    n = 0;
    while (!bus.out_valid && n < 20) begin tick(); n++; end
    chk("t3_out_pc", bus.out_pc, 32'h100);
    chk("t3_out_inst", bus.out_inst, word(32'h100));

    // 4: redirect coincident with an ack
    n = 0;
    while (!bus.mem_ack && n < 20) begin tick(); n++; end
    chk("t4_ack_seen", bus.mem_ack, 1);
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h40;
    tick();
    bus.redirect = 1'b0;
    chk("t4_flushed", bus.out_valid, 0);
    chk("t4_req", bus.mem_req, 1);
    chk("t4_addr", bus.mem_addr, 32'h40);
    bus.out_ready = 1'b1;
    p0 = pops;
    n = 0;
    while (pops < p0 + 3 && n < 40) begin tick(); n++; end
    chk("t4_progress", pops >= p0 + 3, 1);

    // 5: address wrap at the top of memory; low bits of redirect_pc ignored
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFF;
    tick();
    bus.redirect = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 30) begin tick(); n++; end
    chk("t5_top_pc", bus.out_pc, 32'hFFFF_FFFC);
    tick();
    n = 0;
    while (!bus.out_valid && n < 30) begin tick(); n++; end
    chk("t5_wrap_pc", bus.out_pc, 32'h0);
    chk("t5_wrap_inst", bus.out_inst, word(32'h0));

    // 6: reset while a request is outstanding
    lat_min = 5; lat_max = 5;
    n = 0;
    while (!bus.mem_ack && n < 20) begin tick(); n++; end
    tick();
    tick();
    chk("t6_in_wait", bus.mem_req, 1);
    reset = 1'b1;
    tick();
    chk("t6_req_dropped", bus.mem_req, 0);
    chk("t6_valid_cleared", bus.out_valid, 0);
`ifdef IFQ_STATS_EN
    chk("t6_stat_fetched_zero", stat_fetched, 0);
`endif
    reset = 1'b0;
    tick();
    n = 0;
    while (!bus.mem_req && n < 10) begin tick(); n++; end
    chk("t6_restart_req", bus.mem_req, 1);
    chk("t6_restart_addr", bus.mem_addr, RESET_PC);

    // Randomized traffic: variable latency, random stalls and redirects
    lat_min = 0; lat_max = 4;
    p0 = pops;
    for (int i = 0; i < 1500; i++) begin
      bus.out_ready = ($urandom_range(9, 0) < 7);
      bus.redirect = ($urandom_range(31, 0) == 0);
      bus.redirect_pc = $urandom();
      tick();
    end
    bus.redirect = 1'b0;
    chk("rand_progress", pops > p0 + 100, 1);
`ifdef IFQ_STATS_EN
    chk("stat_fetched_vs_pops", stat_fetched >= pops_since_reset, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
